// File: rtl/hazard_pkg.sv
// Shared definitions for the hazard/forwarding controller slice.
//   FWD_RF     : forward-select value meaning "read the register file"
//   REG_ADDR_W : default register address width
//   sel_width  : width of one forward select for a given stage count
package hazard_pkg;

    localparam int unsigned REG_ADDR_W = 5;
    localparam int unsigned FWD_RF     = 0;

    function automatic int unsigned sel_width(input int unsigned numStg);
        return $clog2(numStg + 1);
    endfunction

endpackage

// File: rtl/hazard_forward_ctrl_if.sv
// Pipeline-side bundle of the hazard/forwarding controller.
//   master : pipeline control (drives ID/EX/stage/LL fields, reads results)
//   slave  : controller (reads control fields, drives fwd_sel/stall/stall_cnt)
interface hazard_forward_ctrl_if #(
    parameter int unsigned REG_ADDR_W = 5,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned NUM_STG    = 2,
    parameter int unsigned SEL_W      = 2,
    parameter int unsigned CNT_W      = 16
);
    logic                          id_valid;
    logic [NUM_SRC*REG_ADDR_W-1:0] id_src;
    logic [NUM_SRC-1:0]            id_src_used;
    logic                          id_ll;
    logic [REG_ADDR_W-1:0]         id_rd;
    logic [NUM_SRC*REG_ADDR_W-1:0] ex_src;
    logic                          ex_is_load;
    logic [REG_ADDR_W-1:0]         ex_rd;
    logic [NUM_STG-1:0]            stg_regwrite;
    logic [NUM_STG*REG_ADDR_W-1:0] stg_rd;
    logic                          ll_done;
    logic [REG_ADDR_W-1:0]         ll_rd;
    logic [NUM_SRC*SEL_W-1:0]      fwd_sel;
    logic                          stall;
    logic [CNT_W-1:0]              stall_cnt;

    modport master (
        output id_valid, id_src, id_src_used, id_ll, id_rd,
        output ex_src, ex_is_load, ex_rd,
        output stg_regwrite, stg_rd, ll_done, ll_rd,
        input  fwd_sel, stall, stall_cnt
    );

    modport slave (
        input  id_valid, id_src, id_src_used, id_ll, id_rd,
        input  ex_src, ex_is_load, ex_rd,
        input  stg_regwrite, stg_rd, ll_done, ll_rd,
        output fwd_sel, stall, stall_cnt
    );
endinterface

// File: rtl/hazard_forward_ctrl_reg_scoreboard.sv
// Register scoreboard: one pending bit per architectural register.
//   clk, reset     : clock, async active-high reset (clears all pending bits)
//   setEn/setRd    : mark register pending at next edge (wins over clear)
//   clrEn/clrRd    : clear register at next edge; also bypasses lookups now
//   lookupSrc/Used : per-operand source registers and read flags
//   wawRd          : destination register checked for a pending write
//   srcPending     : per-operand "used and still pending"
//   wawPending     : wawRd still pending
module reg_scoreboard import hazard_pkg::*; #(
    parameter int unsigned REG_ADDR_W = hazard_pkg::REG_ADDR_W,
    parameter int unsigned NUM_SRC    = 2
) (
    input  logic                          clk,
    input  logic                          reset,
    input  logic                          setEn,
    input  logic [REG_ADDR_W-1:0]         setRd,
    input  logic                          clrEn,
    input  logic [REG_ADDR_W-1:0]         clrRd,
    input  logic [NUM_SRC*REG_ADDR_W-1:0] lookupSrc,
    input  logic [NUM_SRC-1:0]            lookupUsed,
    input  logic [REG_ADDR_W-1:0]         wawRd,
    output logic [NUM_SRC-1:0]            srcPending,
    output logic                          wawPending
);
    localparam int unsigned NUM_REG = 1 << REG_ADDR_W;

    logic [NUM_REG-1:0] pending;
    logic [NUM_REG-1:0] pendVisible;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pending <= '0;
        end else begin
            if (clrEn) pending[clrRd] <= 1'b0;
            // Later assignment: an issue to the same register overrides completion.
            if (setEn) pending[setRd] <= 1'b1;
            pending[0] <= 1'b0;
        end
    end

    // A write-back presented this cycle already satisfies its consumers.
    always_comb begin
        pendVisible = pending;
        if (clrEn) pendVisible[clrRd] = 1'b0;
    end

    always_comb begin
        srcPending = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            srcPending[i] = lookupUsed[i] & pendVisible[lookupSrc[i*REG_ADDR_W +: REG_ADDR_W]];
        end
        wawPending = pendVisible[wawRd];
    end

endmodule

// File: rtl/hazard_forward_ctrl.sv
// Hazard and forwarding controller beside the ID/EX pipeline register.
//   clk   : clock
//   reset : async active-high reset
//   bus   : control fields in (ID, EX, forwarding stages, LL write-back),
//           fwd_sel / stall / stall_cnt out
// fwd_sel and stall are purely combinational; stall_cnt saturates.
module hazard_forward_ctrl import hazard_pkg::*; #(
    parameter int unsigned REG_ADDR_W = hazard_pkg::REG_ADDR_W,
    parameter int unsigned NUM_SRC    = 2,
    parameter int unsigned NUM_STG    = 2,
    parameter int unsigned SEL_W      = sel_width(NUM_STG),
    parameter int unsigned CNT_W      = 16
) (
    input  logic                clk,
    input  logic                reset,
    hazard_forward_ctrl_if.slave bus
);
    logic [NUM_SRC*SEL_W-1:0] fwdSel;
    logic                     loadUse;
    logic                     sbHazard;
    logic                     stallInt;
    logic                     issue;
    logic [NUM_SRC-1:0]       srcPending;
    logic                     wawPending;
    logic [CNT_W-1:0]         stallCnt;

    // Scan oldest to youngest so the youngest matching stage is assigned last.
    always_comb begin
        fwdSel = '0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            fwdSel[i*SEL_W +: SEL_W] = SEL_W'(FWD_RF);
            for (int unsigned j = 0; j < NUM_STG; j++) begin
                if (bus.stg_regwrite[NUM_STG-1-j] &&
                    bus.stg_rd[(NUM_STG-1-j)*REG_ADDR_W +: REG_ADDR_W] != '0 &&
                    bus.stg_rd[(NUM_STG-1-j)*REG_ADDR_W +: REG_ADDR_W] ==
                        bus.ex_src[i*REG_ADDR_W +: REG_ADDR_W]) begin
                    fwdSel[i*SEL_W +: SEL_W] = SEL_W'(NUM_STG - j);
                end
            end
        end
    end

    always_comb begin
        loadUse = 1'b0;
        for (int unsigned i = 0; i < NUM_SRC; i++) begin
            if (bus.id_src_used[i] && bus.id_src[i*REG_ADDR_W +: REG_ADDR_W] == bus.ex_rd) begin
                loadUse = 1'b1;
            end
        end
        loadUse = loadUse & bus.id_valid & bus.ex_is_load & (bus.ex_rd != '0);
    end

    reg_scoreboard #(
        .REG_ADDR_W (REG_ADDR_W),
        .NUM_SRC    (NUM_SRC)
    ) uScoreboard (
        .clk        (clk),
        .reset      (reset),
        .setEn      (issue),
        .setRd      (bus.id_rd),
        .clrEn      (bus.ll_done),
        .clrRd      (bus.ll_rd),
        .lookupSrc  (bus.id_src),
        .lookupUsed (bus.id_src_used),
        .wawRd      (bus.id_rd),
        .srcPending (srcPending),
        .wawPending (wawPending)
    );

    assign sbHazard = bus.id_valid & ((|srcPending) | (bus.id_ll & wawPending));
    assign stallInt = loadUse | sbHazard;
    assign issue    = bus.id_valid & ~stallInt & bus.id_ll & (bus.id_rd != '0);

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            stallCnt <= '0;
        end else if (stallInt && stallCnt != '1) begin
            stallCnt <= stallCnt + 1'b1;
        end
    end

    assign bus.fwd_sel   = fwdSel;
    assign bus.stall     = stallInt;
    assign bus.stall_cnt = stallCnt;

endmodule

// File: tb/tb_hazard_forward_ctrl.sv
module tb_hazard_forward_ctrl;

    logic clk;
    logic reset;

    typedef struct {
        string       name;
        logic [3:0]  fwd;
        logic        stall;
        logic [15:0] cnt;
        logic [3:0]  cnt4;
    } exp_t;

    exp_t q[$];
    int   nAssert = 0;
    int   nFail   = 0;
    logic [15:0] expCnt = '0;

    hazard_forward_ctrl_if #(.REG_ADDR_W(5), .NUM_SRC(2), .NUM_STG(2), .SEL_W(2), .CNT_W(16)) bus ();
    hazard_forward_ctrl_if #(.REG_ADDR_W(5), .NUM_SRC(2), .NUM_STG(2), .SEL_W(2), .CNT_W(4))  bus4 ();

    hazard_forward_ctrl #(.REG_ADDR_W(5), .NUM_SRC(2), .NUM_STG(2), .SEL_W(2), .CNT_W(16)) dut (
        .clk(clk), .reset(reset), .bus(bus)
    );
    hazard_forward_ctrl #(.REG_ADDR_W(5), .NUM_SRC(2), .NUM_STG(2), .SEL_W(2), .CNT_W(4)) dut4 (
        .clk(clk), .reset(reset), .bus(bus4)
    );

    // The narrow-counter instance sees identical stimulus.
    assign bus4.id_valid     = bus.id_valid;
    assign bus4.id_src       = bus.id_src;
    assign bus4.id_src_used  = bus.id_src_used;
    assign bus4.id_ll        = bus.id_ll;
    assign bus4.id_rd        = bus.id_rd;
    assign bus4.ex_src       = bus.ex_src;
    assign bus4.ex_is_load   = bus.ex_is_load;
    assign bus4.ex_rd        = bus.ex_rd;
    assign bus4.stg_regwrite = bus.stg_regwrite;
    assign bus4.stg_rd       = bus.stg_rd;
    assign bus4.ll_done      = bus.ll_done;
    assign bus4.ll_rd        = bus.ll_rd;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input string field, input logic [15:0] act, input logic [15:0] exp);
        nAssert++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s.%s: got %0h, expected %0h", name, field, act, exp);
        end
    endtask

    // Monitor: outputs are combinational, so compare once per cycle at negedge.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                chk(e.name, "fwd_sel",    16'(bus.fwd_sel),    16'(e.fwd));
                chk(e.name, "stall",      16'(bus.stall),      16'(e.stall));
                chk(e.name, "stall_cnt",  bus.stall_cnt,       e.cnt);
                chk(e.name, "stall_cnt4", 16'(bus4.stall_cnt), 16'(e.cnt4));
                chk(e.name, "stall4",     16'(bus4.stall),     16'(e.stall));
            end
        end
    end

    task automatic push(input string name, input logic [3:0] fwd, input logic st);
        exp_t e;
        e.name  = name;
        e.fwd   = fwd;
        e.stall = st;
        e.cnt   = expCnt;
        e.cnt4  = (expCnt > 16'd15) ? 4'hf : expCnt[3:0];
        q.push_back(e);
    endtask

    // Push the expectation for the current cycle, then advance one edge.
    task automatic cyc(input string name, input logic [3:0] fwd, input logic st);
        push(name, fwd, st);
        @(posedge clk);
        if (st && !reset && expCnt != 16'hffff) expCnt++;
        #1;
    endtask

    task automatic idle();
        bus.id_valid     = 1'b0;
        bus.id_src       = '0;
        bus.id_src_used  = '0;
        bus.id_ll        = 1'b0;
        bus.id_rd        = '0;
        bus.ex_src       = '0;
        bus.ex_is_load   = 1'b0;
        bus.ex_rd        = '0;
        bus.stg_regwrite = '0;
        bus.stg_rd       = '0;
        bus.ll_done      = 1'b0;
        bus.ll_rd        = '0;
    endtask

    initial begin
        idle();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
        cyc("reset", 4'h0, 1'b0);

        // Forwarding priority
        bus.ex_src = {5'd0, 5'd5};
        bus.stg_rd = {5'd5, 5'd5};
        bus.stg_regwrite = 2'b11;
        cyc("fwd_both", 4'h1, 1'b0);
        bus.stg_regwrite = 2'b10;
        cyc("fwd_stg1", 4'h2, 1'b0);
        bus.stg_regwrite = 2'b11;
        bus.stg_rd = {5'd0, 5'd0};
        bus.ex_src = {5'd0, 5'd0};
        cyc("fwd_rd0", 4'h0, 1'b0);
        bus.ex_src = {5'd6, 5'd5};
        bus.stg_rd = {5'd6, 5'd5};
        cyc("fwd_split", 4'h9, 1'b0);
        idle();

        // Load-use
        bus.id_valid = 1'b1;
        bus.id_src = {5'd3, 5'd0};
        bus.id_src_used = 2'b10;
        bus.ex_is_load = 1'b1;
        bus.ex_rd = 5'd3;
        cyc("loaduse", 4'h0, 1'b1);
        bus.ex_is_load = 1'b0;
        bus.ex_rd = 5'd0;
        cyc("loaduse_bubble", 4'h0, 1'b0);
        bus.ex_is_load = 1'b1;
        bus.ex_rd = 5'd3;
        bus.id_src_used = 2'b01;
        cyc("loaduse_unused", 4'h0, 1'b0);
        idle();

        // Scoreboard RAW
        bus.id_valid = 1'b1;
        bus.id_ll = 1'b1;
        bus.id_rd = 5'd7;
        cyc("ll_issue7", 4'h0, 1'b0);
        bus.id_ll = 1'b0;
        bus.id_rd = 5'd0;
        bus.id_src = {5'd0, 5'd7};
        bus.id_src_used = 2'b01;
        repeat (4) cyc("raw7_stall", 4'h0, 1'b1);
        bus.ll_done = 1'b1;
        bus.ll_rd = 5'd7;
        cyc("raw7_bypass", 4'h0, 1'b0);
        bus.ll_done = 1'b0;
        bus.ll_rd = 5'd0;
        cyc("raw7_cleared", 4'h0, 1'b0);
        idle();

        // WAW and simultaneous issue/complete
        bus.id_valid = 1'b1;
        bus.id_ll = 1'b1;
        bus.id_rd = 5'd9;
        cyc("ll_issue9", 4'h0, 1'b0);
        cyc("waw9", 4'h0, 1'b1);
        bus.ll_done = 1'b1;
        bus.ll_rd = 5'd9;
        cyc("waw9_bypass", 4'h0, 1'b0);
        bus.ll_done = 1'b0;
        bus.ll_rd = 5'd0;
        bus.id_ll = 1'b0;
        bus.id_rd = 5'd0;
        bus.id_src = {5'd9, 5'd0};
        bus.id_src_used = 2'b10;
        cyc("set_wins9", 4'h0, 1'b1);
        bus.ll_done = 1'b1;
        bus.ll_rd = 5'd9;
        cyc("raw9_bypass", 4'h0, 1'b0);
        bus.ll_done = 1'b0;
        bus.ll_rd = 5'd0;
        cyc("raw9_cleared", 4'h0, 1'b0);
        idle();

        // Reset mid-stall
        bus.id_valid = 1'b1;
        bus.id_ll = 1'b1;
        bus.id_rd = 5'd12;
        cyc("ll_issue12", 4'h0, 1'b0);
        bus.id_ll = 1'b0;
        bus.id_rd = 5'd0;
        bus.id_src = {5'd0, 5'd12};
        bus.id_src_used = 2'b01;
        cyc("raw12_stall", 4'h0, 1'b1);
        #1 reset = 1'b1;
        expCnt = '0;
        cyc("reset_async", 4'h0, 1'b0);
        reset = 1'b0;
        cyc("post_reset12", 4'h0, 1'b0);
        idle();

        // Saturation: 20 load-use cycles
        bus.id_valid = 1'b1;
        bus.id_src = {5'd3, 5'd0};
        bus.id_src_used = 2'b10;
        bus.ex_is_load = 1'b1;
        bus.ex_rd = 5'd3;
        repeat (20) cyc("sat_hold", 4'h0, 1'b1);
        idle();
        cyc("sat_end", 4'h0, 1'b0);

        for (int i = 0; i < 20 && q.size() > 0; i++) @(posedge clk);
        if (q.size() > 0) begin
            nAssert++;
            nFail++;
            $display("FAIL drain: %0d expectations unchecked, expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", nAssert, nFail);
        $finish;
    end

endmodule
